mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_responder_ram.sv | 26 ++
 rtl/mem_responder.sv | 95 +++++++++
 tb/tb_mem_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared command encodings and default geometry for the memory responder.
package mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;

    localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
    localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        MNONE    = 2'b00,
        MREAD    = 2'b01,
        MWRITE   = 2'b10,
        MILLEGAL = 2'b11
    } mem_cmd_e;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port RAM: synchronous write, registered read, write-first on a shared address.
module ram #(
    parameter int WORDS  = 256,
    parameter int DATA_W = 16,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-mapped responder: RAM window, LED register, synchronized switch port and sticky fault flag.
module mem_responder
    import mem_pkg::*;
#(
    parameter int                DATA_W    = mem_pkg::DATA_W,
    parameter int                ADDR_W    = mem_pkg::ADDR_W,
    parameter int                RAM_WORDS = 256,
    parameter logic [ADDR_W-1:0] LED_ADDR  = mem_pkg::LED_ADDR,
    parameter logic [ADDR_W-1:0] SW_ADDR   = mem_pkg::SW_ADDR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [7:0]        sw,
    output logic [DATA_W-1:0] read_data,
    output logic              rd_valid,
    output logic [7:0]        led,
    output logic              err
);

    localparam int IDX_W = $clog2(RAM_WORDS);

    mem_cmd_e          cmd;
    logic              active;
    logic              ram_hit, led_hit, sw_hit;
    logic              do_rd, do_wr, fault;
    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] io_q;
    logic              src_ram;
    logic [7:0]        sw_meta, sw_sync;

    assign cmd = mem_cmd_e'(mem_cmd);

    // Full-width compare so nothing above the RAM window aliases into it.
    assign ram_hit = ({1'b0, mem_addr} < (ADDR_W+1)'(RAM_WORDS));
    assign led_hit = (mem_addr == LED_ADDR);
    assign sw_hit  = (mem_addr == SW_ADDR);

    // active stays low for the first edge after reset release, so that edge's command is dropped.
    assign do_rd  = active && (cmd == MREAD);
    assign do_wr  = active && (cmd == MWRITE);
    assign fault  = (do_rd && !ram_hit && !sw_hit)
                 || (do_wr && !ram_hit && !led_hit)
                 || (active && (cmd == MILLEGAL));

    assign ram_we = do_wr && ram_hit;
    assign ram_re = do_rd && ram_hit;

    ram #(
        .WORDS  (RAM_WORDS),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (mem_addr[IDX_W-1:0]),
        .wdata (write_data),
        .rdata (ram_q)
    );

    // RAM output register and io_q both hold between reads; src_ram picks whichever was loaded last.
    assign read_data = src_ram ? ram_q : io_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active   <= 1'b0;
            sw_meta  <= '0;
            sw_sync  <= '0;
            src_ram  <= 1'b0;
            io_q     <= '0;
            rd_valid <= 1'b0;
            led      <= '0;
            err      <= 1'b0;
        end else begin
            active   <= 1'b1;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            rd_valid <= do_rd;
            if (do_rd) begin
                src_ram <= ram_hit;
                io_q    <= sw_hit ? {{(DATA_W-8){1'b0}}, sw_sync} : '0;
            end
            if (do_wr && led_hit) begin
                led <= write_data[7:0];
            end
            if (fault) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against an address-map reference model.
module tb_mem_responder;

    localparam logic [1:0] C_NONE = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_ILL = 2'b11;
    localparam logic [8:0] A_LED = 9'h100, A_SW = 9'h140;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  mem_cmd = C_NONE;
    logic [8:0]  mem_addr = '0;
    logic [15:0] write_data = '0;
    logic [7:0]  sw = '0;
    logic [15:0] read_data;
    logic        rd_valid;
    logic [7:0]  led;
    logic        err;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .sw         (sw),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .led        (led),
        .err        (err)
    );

    logic [15:0] ram_m [256];
    logic [15:0] rd_m;
    logic        vld_m, err_m;
    logic [7:0]  led_m, sw_m;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".read_data"}, 32'(read_data), 32'(rd_m));
        chk({tag, ".rd_valid"},  32'(rd_valid),  32'(vld_m));
        chk({tag, ".led"},       32'(led),       32'(led_m));
        chk({tag, ".err"},       32'(err),       32'(err_m));
    endtask

    task automatic model_reset();
        rd_m = '0; vld_m = 1'b0; err_m = 1'b0; led_m = '0;
    endtask

    // Called at a negedge: present the command, let one rising edge act, check at the next negedge.
    task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd = c; mem_addr = a; write_data = d;
        @(posedge clk);
        vld_m = (c == C_RD);
        case (c)
            C_RD: begin
                if (a < 9'h100)      rd_m = ram_m[a[7:0]];
                else if (a == A_SW)  rd_m = {8'h00, sw_m};
                else begin rd_m = '0; err_m = 1'b1; end
            end
            C_WR: begin
                if (a < 9'h100)      ram_m[a[7:0]] = d;
                else if (a == A_LED) led_m = d[7:0];
                else                 err_m = 1'b1;
            end
            C_ILL:   err_m = 1'b1;
            default: ;
        endcase
        @(negedge clk);
        chk_all("step");
    endtask

    function automatic logic [8:0] rand_addr();
        logic [8:0] odd [5];
        odd = '{A_LED, A_SW, 9'h1FF, 9'h180, 9'h101};
        if ($urandom_range(99) < 85) return 9'($urandom_range(255));
        return odd[$urandom_range(4)];
    endfunction

    initial begin
        int r;
        model_reset();
        sw_m = '0;
        repeat (3) @(negedge clk);
        chk_all("reset");
        reset_n = 1'b1;
        repeat (3) step(C_NONE, '0, '0);

        // Known contents everywhere so every later read has a defined expectation.
        for (int i = 0; i < 256; i++) step(C_WR, 9'(i), 16'($urandom));
        for (int i = 0; i < 8; i++) step(C_RD, 9'($urandom_range(255)), '0);

        step(C_WR, 9'h006, 16'hFFFF);
        step(C_RD, 9'h006, '0);
        chk("s33.data", 32'(read_data), 32'h0000FFFF);
        chk("s33.vld",  32'(rd_valid),  32'd1);

        step(C_WR, 9'h011, 16'hFFFF);
        step(C_RD, 9'h011, '0);
        chk("s34.data", 32'(read_data), 32'h0000FFFF);
        step(C_NONE, 9'h011, 16'h0000);
        chk("s34.hold", 32'(read_data), 32'h0000FFFF);
        chk("s34.vld",  32'(rd_valid),  32'd0);
        step(C_WR, 9'h011, 16'h0BAD);
        chk("s34.whold", 32'(read_data), 32'h0000FFFF);

        step(C_WR, A_LED, 16'h1234);
        chk("s35.led", 32'(led), 32'h34);
        chk("s35.err", 32'(err), 32'd0);

        sw = 8'hA5; sw_m = 8'hA5;
        step(C_NONE, '0, '0);
        step(C_NONE, '0, '0);
        step(C_RD, A_SW, '0);
        chk("s36.sw", 32'(read_data), 32'h000000A5);
        chk("s36.err", 32'(err), 32'd0);

        step(C_RD, A_LED, '0);
        chk("s35.rdled", 32'(read_data), 32'd0);
        chk("s35.err1",  32'(err), 32'd1);

        step(C_RD, 9'h006, '0);
        step(C_ILL, 9'h011, 16'h5555);
        chk("s37.ill_hold", 32'(read_data), 32'h0000FFFF);
        chk("s37.ill_err",  32'(err), 32'd1);

        // Mid-cycle reset, with a write presented across an edge while held.
        #2 reset_n = 1'b0;
        mem_cmd = C_WR; mem_addr = 9'h006; write_data = 16'h0000;
        #1;
        model_reset();
        chk_all("s37.async");
        @(posedge clk);
        @(negedge clk);
        chk_all("s37.held");
        reset_n = 1'b1;
        repeat (3) step(C_NONE, '0, '0);
        step(C_RD, 9'h006, '0);
        chk("s37.ram_kept", 32'(read_data), 32'h0000FFFF);

        // Random traffic with a fresh sw value settled first.
        sw = 8'($urandom); sw_m = sw;
        step(C_NONE, '0, '0);
        step(C_NONE, '0, '0);
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(99);
            if (r < 45)      step(C_RD, rand_addr(), 16'($urandom));
            else if (r < 90) step(C_WR, rand_addr(), 16'($urandom));
            else if (r < 98) step(C_NONE, rand_addr(), 16'($urandom));
            else             step(C_ILL, rand_addr(), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
